dispatch_unit: RTL and testbench

- Sits between the renamer and the issue queues, and is the transmitter side of the issue-queue insert interface.
- Buffers renamed instructions in a small in-order FIFO and routes the head to the issue queue selected by iq_sel.
- Owns the PRN busy table and supplies each operand's prn_input_ready bit, including a same-cycle wakeup bypass. The bypass is needed because an issue queue does not wake an entry in the cycle it is inserted.

---
 rtl/dispatch_unit_pkg.sv | 33 +++
 rtl/dispatch_unit_if.sv | 61 ++++++
 rtl/dispatch_unit_busy.sv | 66 ++++++
 rtl/dispatch_unit.sv | 147 ++++++++++++++
 tb/tb_dispatch_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_unit_pkg.sv
// +------------------------------------------------------------------+
// | foxtrot_dispatch_pkg: dispatch entry layout and shared constants |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package foxtrot_dispatch_pkg;

    localparam int PRN_ZERO        = 0;
    localparam int DU_INST_ID_BITS = 6;
    localparam int DU_PRN_BITS     = 6;
    localparam int DU_MAX_OPERANDS = 3;
    localparam int DU_IQ_COUNT     = 4;
    localparam int DU_IQ_SEL_BITS  = (DU_IQ_COUNT > 1) ? $clog2(DU_IQ_COUNT) : 1;

    typedef struct packed {
        logic [DU_INST_ID_BITS-1:0]                    inst_id;
        logic [31:0]                                   raw_instr;
        logic [63:0]                                   pc;
        logic [DU_IQ_SEL_BITS-1:0]                     iq_sel;
        logic [DU_MAX_OPERANDS-1:0]                    src_valid;
        logic [DU_MAX_OPERANDS-1:0][DU_PRN_BITS-1:0]   src_prn;
        logic [DU_MAX_OPERANDS-1:0]                    dst_valid;
        logic [DU_MAX_OPERANDS-1:0][DU_PRN_BITS-1:0]   dst_prn;
    } dispatch_entry_t;

    function automatic logic [DU_IQ_COUNT-1:0] iq_onehot(input logic [DU_IQ_SEL_BITS-1:0] sel);
        return DU_IQ_COUNT'(1) << sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_unit_if.sv
// +------------------------------------------------------------------+
// | dispatch_unit_if: renamer, wakeup and issue-queue insert signals |
// | master = dispatch unit, slave = surrounding pipeline. Rev 1.0    |
// +------------------------------------------------------------------+
`default_nettype none

interface dispatch_unit_if #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int IQ_COUNT     = 4
);
    localparam int IQ_SEL_BITS = (IQ_COUNT > 1) ? $clog2(IQ_COUNT) : 1;

    logic                                         ren_valid;
    logic                                         ren_ready;
    logic [INST_ID_BITS-1:0]                      ren_inst_id;
    logic [31:0]                                  ren_raw_instr;
    logic [63:0]                                  ren_pc;
    logic [IQ_SEL_BITS-1:0]                       ren_iq_sel;
    logic [MAX_OPERANDS-1:0]                      ren_src_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        ren_src_prn;
    logic [MAX_OPERANDS-1:0]                      ren_dst_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        ren_dst_prn;

    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                set_prn_ready;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  set_prn;

    logic [IQ_COUNT-1:0]                          iq_queue_ready;
    logic [IQ_COUNT-1:0]                          iq_inst_valid;
    logic [INST_ID_BITS-1:0]                      iq_inst_id;
    logic [31:0]                                  iq_raw_instr;
    logic [63:0]                                  iq_pc;
    logic [MAX_OPERANDS-1:0]                      iq_prn_input_valid;
    logic [MAX_OPERANDS-1:0]                      iq_prn_input_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        iq_prn_input;
    logic [MAX_OPERANDS-1:0]                      iq_prn_output_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]        iq_prn_output;

    modport master (
        input  ren_valid, ren_inst_id, ren_raw_instr, ren_pc, ren_iq_sel,
               ren_src_valid, ren_src_prn, ren_dst_valid, ren_dst_prn,
               set_prn_ready, set_prn, iq_queue_ready,
        output ren_ready, iq_inst_valid, iq_inst_id, iq_raw_instr, iq_pc,
               iq_prn_input_valid, iq_prn_input_ready, iq_prn_input,
               iq_prn_output_valid, iq_prn_output
    );

    modport slave (
        output ren_valid, ren_inst_id, ren_raw_instr, ren_pc, ren_iq_sel,
               ren_src_valid, ren_src_prn, ren_dst_valid, ren_dst_prn,
               set_prn_ready, set_prn, iq_queue_ready,
        input  ren_ready, iq_inst_valid, iq_inst_id, iq_raw_instr, iq_pc,
               iq_prn_input_valid, iq_prn_input_ready, iq_prn_input,
               iq_prn_output_valid, iq_prn_output
    );

endinterface

`default_nettype wire

// File: rtl/dispatch_unit_busy.sv
// +------------------------------------------------------------------+
// | prn_busy_table: per-PRN busy bits with same-cycle wakeup bypass  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module prn_busy_table
    import foxtrot_dispatch_pkg::*;
#(
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [MAX_OPERANDS-1:0]                           set_en_i,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             set_prn_i,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]             clr_en_i,
    input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] clr_prn_i,
    input  logic [MAX_OPERANDS-1:0]                           qry_valid_i,
    input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]             qry_prn_i,
    output logic [MAX_OPERANDS-1:0]                           qry_ready_o
);

    localparam int NUM_PRN = 1 << PRN_BITS;

    logic [NUM_PRN-1:0]      busy_q;
    logic [NUM_PRN-1:0]      busy_d;
    logic [MAX_OPERANDS-1:0] hit;

    // Clears are applied first so a same-cycle allocation of the same PRN wins.
    always_comb begin
        busy_d = busy_q;
        for (int f = 0; f < FU_COUNT; f++) begin
            for (int o = 0; o < MAX_OPERANDS; o++) begin
                if (clr_en_i[f][o]) busy_d[clr_prn_i[f][o]] = 1'b0;
            end
        end
        for (int o = 0; o < MAX_OPERANDS; o++) begin
            if (set_en_i[o]) busy_d[set_prn_i[o]] = 1'b1;
        end
        busy_d[PRN_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy_q <= '0;
        else      busy_q <= busy_d;
    end

    always_comb begin
        hit         = '0;
        qry_ready_o = '0;
        for (int i = 0; i < MAX_OPERANDS; i++) begin
            for (int f = 0; f < FU_COUNT; f++) begin
                for (int o = 0; o < MAX_OPERANDS; o++) begin
                    if (clr_en_i[f][o] && clr_prn_i[f][o] == qry_prn_i[i]) hit[i] = 1'b1;
                end
            end
            qry_ready_o[i] = !qry_valid_i[i] || (qry_prn_i[i] == PRN_BITS'(PRN_ZERO))
                             || !busy_q[qry_prn_i[i]] || hit[i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/dispatch_unit.sv
// +------------------------------------------------------------------+
// | dispatch_unit: in-order dispatch FIFO feeding the issue queues   |
// | Optional perf counters: FOXTROT_DISPATCH_PERF_EN. Revision 1.0   |
// +------------------------------------------------------------------+
`default_nettype none

module dispatch_unit
    import foxtrot_dispatch_pkg::*;
#(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int IQ_COUNT     = 4,
    parameter int BUF_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    dispatch_unit_if.master bus
`ifdef FOXTROT_DISPATCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_iq,
    output logic [31:0]     perf_stall_full,
    output logic [31:0]     perf_dispatched
`endif
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    if (INST_ID_BITS != DU_INST_ID_BITS || PRN_BITS != DU_PRN_BITS ||
        MAX_OPERANDS != DU_MAX_OPERANDS || IQ_COUNT != DU_IQ_COUNT ||
        BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_param_check
        $error("dispatch_unit: parameters inconsistent with foxtrot_dispatch_pkg");
    end

    dispatch_entry_t   fifo_q [BUF_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    dispatch_entry_t   new_entry;
    dispatch_entry_t   head;
    logic              full;
    logic              head_valid;
    logic              push;
    logic              fire;

    // ren_ready depends only on the registered count, never on this cycle's pop.
    assign full       = (count_q == CNT_W'(BUF_DEPTH));
    assign head_valid = (count_q != '0);
    assign head       = head_valid ? fifo_q[head_q] : '0;
    assign push       = bus.ren_valid && !full;
    assign fire       = head_valid && bus.iq_queue_ready[head.iq_sel];

    always_comb begin
        new_entry           = '0;
        new_entry.inst_id   = bus.ren_inst_id;
        new_entry.raw_instr = bus.ren_raw_instr;
        new_entry.pc        = bus.ren_pc;
        new_entry.iq_sel    = bus.ren_iq_sel;
        new_entry.src_valid = bus.ren_src_valid;
        new_entry.src_prn   = bus.ren_src_prn;
        new_entry.dst_valid = bus.ren_dst_valid;
        new_entry.dst_prn   = bus.ren_dst_prn;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (fire) head_d = head_q + PTR_W'(1);
        if (push) tail_d = tail_q + PTR_W'(1);
        case ({push, fire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[tail_q] <= new_entry;
    end

    assign bus.ren_ready           = !full;
    assign bus.iq_inst_valid       = fire ? iq_onehot(head.iq_sel) : '0;
    assign bus.iq_inst_id          = head.inst_id;
    assign bus.iq_raw_instr        = head.raw_instr;
    assign bus.iq_pc               = head.pc;
    assign bus.iq_prn_input_valid  = head.src_valid;
    assign bus.iq_prn_input        = head.src_prn;
    assign bus.iq_prn_output_valid = head.dst_valid;
    assign bus.iq_prn_output       = head.dst_prn;

    prn_busy_table #(
        .PRN_BITS     (PRN_BITS),
        .MAX_OPERANDS (MAX_OPERANDS),
        .FU_COUNT     (FU_COUNT)
    ) u_busy (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (push ? bus.ren_dst_valid : '0),
        .set_prn_i   (bus.ren_dst_prn),
        .clr_en_i    (bus.set_prn_ready),
        .clr_prn_i   (bus.set_prn),
        .qry_valid_i (head.src_valid),
        .qry_prn_i   (head.src_prn),
        .qry_ready_o (bus.iq_prn_input_ready)
    );

`ifdef FOXTROT_DISPATCH_PERF_EN
    logic [31:0] stall_iq_q;
    logic [31:0] stall_full_q;
    logic [31:0] dispatched_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_iq_q   <= '0;
            stall_full_q <= '0;
            dispatched_q <= '0;
        end else begin
            if (head_valid && !fire && stall_iq_q != '1)     stall_iq_q   <= stall_iq_q + 32'd1;
            if (bus.ren_valid && full && stall_full_q != '1) stall_full_q <= stall_full_q + 32'd1;
            if (fire && dispatched_q != '1)                  dispatched_q <= dispatched_q + 32'd1;
        end
    end

    assign perf_stall_iq   = stall_iq_q;
    assign perf_stall_full = stall_full_q;
    assign perf_dispatched = dispatched_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dispatch_unit.sv
// +------------------------------------------------------------------+
// | tb_dispatch_unit: directed stimulus, queue-based reference model |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_dispatch_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dispatch_unit_if #(
        .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .FU_COUNT(4), .IQ_COUNT(4)
    ) bus ();

`ifdef FOXTROT_DISPATCH_PERF_EN
    logic [31:0] perf_stall_iq, perf_stall_full, perf_dispatched;
`endif

    dispatch_unit #(
        .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3),
        .FU_COUNT(4), .IQ_COUNT(4), .BUF_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FOXTROT_DISPATCH_PERF_EN
        ,
        .perf_stall_iq   (perf_stall_iq),
        .perf_stall_full (perf_stall_full),
        .perf_dispatched (perf_dispatched)
`endif
    );

    typedef struct {
        int          id;
        logic [31:0] raw;
        logic [63:0] pc;
        int          iq;
        logic [2:0]  sv;
        logic [17:0] sp;
        logic [2:0]  dv;
        logic [17:0] dp;
    } m_entry_t;

    m_entry_t mq[$];
    bit       mbusy [64];
    bit       live   = 1'b0;
    int       checks = 0;
    int       errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: evaluated at the falling edge, then advanced for the coming rising edge.
    always @(negedge clk) begin : model
        m_entry_t    h;
        m_entry_t    n;
        logic [3:0]  ev;
        logic [2:0]  er;
        bit          hv;
        bit          woke;
        bit          was_full;
        int          p;

        hv = (mq.size() > 0);
        h  = '{default: 0};
        if (hv) h = mq[0];
        ev = '0;
        if (hv && bus.iq_queue_ready[h.iq]) ev[h.iq] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            p    = int'(h.sp[i*6 +: 6]);
            woke = 1'b0;
            for (int f = 0; f < 4; f++)
                for (int o = 0; o < 3; o++)
                    if (bus.set_prn_ready[f][o] && int'(bus.set_prn[f][o]) == p) woke = 1'b1;
            er[i] = !h.sv[i] || p == 0 || !mbusy[p] || woke;
        end

        if (live) begin
            check("ren_ready",     64'(bus.ren_ready),           64'(mq.size() < 2));
            check("iq_inst_valid", 64'(bus.iq_inst_valid),       64'(ev));
            check("iq_inst_id",    64'(bus.iq_inst_id),          64'(h.id));
            check("iq_raw_instr",  64'(bus.iq_raw_instr),        64'(h.raw));
            check("iq_pc",         bus.iq_pc,                    h.pc);
            check("in_valid",      64'(bus.iq_prn_input_valid),  64'(h.sv));
            check("in_prn",        64'(bus.iq_prn_input),        64'(h.sp));
            check("in_ready",      64'(bus.iq_prn_input_ready),  64'(er));
            check("out_valid",     64'(bus.iq_prn_output_valid), 64'(h.dv));
            check("out_prn",       64'(bus.iq_prn_output),       64'(h.dp));
        end

        if (!rst) begin
            mq.delete();
            for (int i = 0; i < 64; i++) mbusy[i] = 1'b0;
            live = 1'b1;
        end else if (live) begin
            was_full = (mq.size() >= 2);
            for (int f = 0; f < 4; f++)
                for (int o = 0; o < 3; o++)
                    if (bus.set_prn_ready[f][o]) mbusy[int'(bus.set_prn[f][o])] = 1'b0;
            if (bus.ren_valid && !was_full)
                for (int o = 0; o < 3; o++)
                    if (bus.ren_dst_valid[o]) mbusy[int'(bus.ren_dst_prn[o])] = 1'b1;
            mbusy[0] = 1'b0;
            if (ev != '0) void'(mq.pop_front());
            if (bus.ren_valid && !was_full) begin
                n.id  = int'(bus.ren_inst_id);
                n.raw = bus.ren_raw_instr;
                n.pc  = bus.ren_pc;
                n.iq  = int'(bus.ren_iq_sel);
                n.sv  = bus.ren_src_valid;
                n.sp  = bus.ren_src_prn;
                n.dv  = bus.ren_dst_valid;
                n.dp  = bus.ren_dst_prn;
                mq.push_back(n);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic offer(input int id, input int iq, input logic [2:0] sv, input logic [17:0] sp,
                         input logic [2:0] dv, input logic [17:0] dp);
        bus.ren_valid     = 1'b1;
        bus.ren_inst_id   = 6'(id);
        bus.ren_raw_instr = 32'hC0DE_0000 | 32'(id);
        bus.ren_pc        = 64'h8000_0000 + 64'(id * 4);
        bus.ren_iq_sel    = 2'(iq);
        bus.ren_src_valid = sv;
        bus.ren_src_prn   = sp;
        bus.ren_dst_valid = dv;
        bus.ren_dst_prn   = dp;
    endtask

    task automatic drop();
        bus.ren_valid     = 1'b0;
        bus.ren_inst_id   = '0;
        bus.ren_raw_instr = '0;
        bus.ren_pc        = '0;
        bus.ren_iq_sel    = '0;
        bus.ren_src_valid = '0;
        bus.ren_src_prn   = '0;
        bus.ren_dst_valid = '0;
        bus.ren_dst_prn   = '0;
    endtask

    task automatic no_wake();
        bus.set_prn_ready = '0;
        bus.set_prn       = '0;
    endtask

    initial begin
        drop();
        no_wake();
        bus.iq_queue_ready = 4'hF;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        settle();
        check("reset_ren_ready", 64'(bus.ren_ready), 64'd1);
        check("reset_strobes",   64'(bus.iq_inst_valid), 64'd0);

        // Single instruction to IQ 2
        offer(5, 2, 3'b000, 18'd0, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t1_strobe", 64'(bus.iq_inst_valid), 64'b0100);
        check("t1_id",     64'(bus.iq_inst_id),    64'd5);
        tick(); settle();
        check("t1_empty",  64'(bus.iq_inst_valid), 64'd0);

        // Producer of PRN 9 then consumer without wakeup
        offer(10, 0, 3'b000, 18'd0, 3'b001, 18'd9);
        tick();
        offer(11, 1, 3'b001, 18'd9, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t2_strobe", 64'(bus.iq_inst_valid),      64'b0010);
        check("t2_ready",  64'(bus.iq_prn_input_ready), 64'b110);
        tick();

        // Consumer of PRN 9 woken in its dispatch cycle
        offer(12, 3, 3'b001, 18'd9, 3'b000, 18'd0);
        tick(); drop();
        bus.set_prn_ready[1][0] = 1'b1;
        bus.set_prn[1][0]       = 6'd9;
        settle();
        check("t3_strobe", 64'(bus.iq_inst_valid),      64'b1000);
        check("t3_bypass", 64'(bus.iq_prn_input_ready), 64'b111);
        tick(); no_wake();
        offer(13, 0, 3'b100, {6'd9, 12'd0}, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t3_cleared", 64'(bus.iq_prn_input_ready), 64'b111);
        tick();

        // Blocked head stalls the younger entry
        bus.iq_queue_ready = 4'b1101;
        offer(20, 1, 3'b000, 18'd0, 3'b000, 18'd0);
        tick();
        offer(21, 0, 3'b000, 18'd0, 3'b000, 18'd0);
        tick();
        offer(22, 2, 3'b000, 18'd0, 3'b000, 18'd0);
        settle();
        check("t4_blocked", 64'(bus.iq_inst_valid), 64'd0);
        check("t4_full",    64'(bus.ren_ready),     64'd0);
        tick(); tick(); drop();
        bus.iq_queue_ready = 4'hF;
        settle();
        check("t4_first",    64'(bus.iq_inst_valid), 64'b0010);
        check("t4_first_id", 64'(bus.iq_inst_id),    64'd20);
        tick(); settle();
        check("t4_second",    64'(bus.iq_inst_valid), 64'b0001);
        check("t4_second_id", 64'(bus.iq_inst_id),    64'd21);
        tick();

        // PRN 0 is never busy
        offer(30, 0, 3'b000, 18'd0, 3'b010, 18'd0);
        tick();
        offer(31, 1, 3'b001, 18'd0, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t5_prn0_ready", 64'(bus.iq_prn_input_ready), 64'b111);
        tick();

        // Same-cycle allocate and wake of PRN 12: allocation wins
        offer(32, 2, 3'b000, 18'd0, 3'b001, 18'd12);
        bus.set_prn_ready[0][2] = 1'b1;
        bus.set_prn[0][2]       = 6'd12;
        tick(); no_wake();
        offer(33, 3, 3'b001, 18'd12, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t5_set_wins", 64'(bus.iq_prn_input_ready), 64'b110);
        tick();

        // Reset with two buffered entries
        bus.iq_queue_ready = 4'h0;
        offer(40, 0, 3'b000, 18'd0, 3'b001, 18'd15);
        tick();
        offer(41, 1, 3'b000, 18'd0, 3'b001, 18'd16);
        tick(); drop(); settle();
        check("t6_full", 64'(bus.ren_ready), 64'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.iq_queue_ready = 4'hF;
        settle();
        check("t6_no_strobe", 64'(bus.iq_inst_valid), 64'd0);
        check("t6_ready",     64'(bus.ren_ready),     64'd1);
        offer(42, 0, 3'b011, {6'd0, 6'd16, 6'd15}, 3'b000, 18'd0);
        tick(); drop(); settle();
        check("t6_strobe",       64'(bus.iq_inst_valid),      64'b0001);
        check("t6_busy_cleared", 64'(bus.iq_prn_input_ready), 64'b111);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
